// File: rtl/updown_pkg.sv
// Shared constants and parameter legality check for the parametrised up/down counter family.
package updown_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // True when the terminal and reset values fit the counter width and range.
    function automatic bit params_ok(input int width, input int max_count, input int init);
        longint lim;
        if (width < 2 || width > 62) return 1'b0;
        lim = (longint'(1) << width) - 64'sd1;
        return (max_count >= 1) && (longint'(max_count) <= lim) &&
               (init >= 0) && (init <= max_count);
    endfunction

endpackage

// File: rtl/updown_counter_param.sv
// Purpose: bidirectional event/position counter with load, enable, wrap or saturate mode.
// Latency: one clk edge from sampled inputs to out/wrap; at_max/at_min decode the register.
// Backpressure: none; accepts a load or step every cycle.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MAX_COUNT = 255,
    parameter int   INIT      = 0,
    parameter logic SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    generate
        if (!params_ok(WIDTH, MAX_COUNT, INIT)) begin : g_bad_params
            $error("updown_counter_param: illegal WIDTH/MAX_COUNT/INIT combination");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    // Terminal compares act on the current value, so a step never overflows past MAX_V.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up_down == DIR_UP) begin
                if (cnt_q == MAX_V) begin
                    if (SATURATE == MODE_WRAP) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == '0) begin
                    if (SATURATE == MODE_WRAP) begin
                        cnt_d  = MAX_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= INIT_V;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign out    = cnt_q;
    assign wrap   = wrap_q;
    assign at_max = (cnt_q == MAX_V);
    assign at_min = (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: three counter configurations share one stimulus set; each task checks its own config.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] out_w;   logic wrap_w, max_w, min_w;   // 8-bit, MAX 255, INIT 3, wrap
    logic [3:0] out_n;   logic wrap_n, max_n, min_n;   // 4-bit, MAX 9, INIT 2, wrap
    logic [7:0] out_s;   logic wrap_s, max_s, min_s;   // 8-bit, MAX 255, INIT 0, saturate

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .MAX_COUNT(255), .INIT(3), .SATURATE(1'b0)) u_wrap8 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .out(out_w), .wrap(wrap_w), .at_max(max_w), .at_min(min_w));

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .INIT(2), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val[3:0]),
        .out(out_n), .wrap(wrap_n), .at_max(max_n), .at_min(min_n));

    updown_counter_param #(.WIDTH(8), .MAX_COUNT(255), .INIT(0), .SATURATE(1'b1)) u_sat8 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .out(out_s), .wrap(wrap_s), .at_max(max_s), .at_min(min_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; up_down = 1'b1; load = 1'b0; load_val = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_w !== 8'd3 || wrap_w !== 1'b0) begin
                errors++;
                $display("FAIL reset_wrap8 cyc%0d: out=%0d wrap=%b, required out=3 wrap=0", i, out_w, wrap_w);
            end
            checks++;
            if (out_n !== 4'd2 || wrap_n !== 1'b0) begin
                errors++;
                $display("FAIL reset_wrap4 cyc%0d: out=%0d wrap=%b, required out=2 wrap=0", i, out_n, wrap_n);
            end
            checks++;
            if (out_s !== 8'd0 || min_s !== 1'b1 || max_s !== 1'b0) begin
                errors++;
                $display("FAIL reset_sat8 cyc%0d: out=%0d at_min=%b at_max=%b, required 0 1 0", i, out_s, min_s, max_s);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_w !== 8'd4 || out_n !== 4'd3 || out_s !== 8'd1) begin
            errors++;
            $display("FAIL reset_release: outs=%0d/%0d/%0d, required 4/3/1", out_w, out_n, out_s);
        end
    endtask

    task automatic test_wrap_up();
        logic [7:0] exp_o [3];
        logic       exp_w [3];
        exp_o = '{8'd255, 8'd0, 8'd1};
        exp_w = '{1'b0, 1'b1, 1'b0};
        load = 1'b1; load_val = 8'd254; en = 1'b1; up_down = 1'b1;
        tick();
        checks++;
        if (out_w !== 8'd254 || wrap_w !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up_load: out=%0d wrap=%b, required 254 0", out_w, wrap_w);
        end
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_w !== exp_o[i] || wrap_w !== exp_w[i]) begin
                errors++;
                $display("FAIL wrap_up step%0d: out=%0d wrap=%b, required %0d %b", i, out_w, wrap_w, exp_o[i], exp_w[i]);
            end
            checks++;
            if (max_w !== (exp_o[i] == 8'd255) || min_w !== (exp_o[i] == 8'd0)) begin
                errors++;
                $display("FAIL wrap_up_flags step%0d: at_max=%b at_min=%b for out=%0d", i, max_w, min_w, exp_o[i]);
            end
        end
    endtask

    task automatic test_wrap_down_npot();
        logic [3:0] exp_o [3];
        logic       exp_w [3];
        exp_o = '{4'd0, 4'd9, 4'd8};
        exp_w = '{1'b0, 1'b1, 1'b0};
        load = 1'b1; load_val = 8'd1; en = 1'b0; up_down = 1'b0;
        tick();
        checks++;
        if (out_n !== 4'd1) begin
            errors++;
            $display("FAIL npot_load1: out=%0d, required 1", out_n);
        end
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_n !== exp_o[i] || wrap_n !== exp_w[i]) begin
                errors++;
                $display("FAIL npot_down step%0d: out=%0d wrap=%b, required %0d %b", i, out_n, wrap_n, exp_o[i], exp_w[i]);
            end
            checks++;
            if (max_n !== (exp_o[i] == 4'd9) || min_n !== (exp_o[i] == 4'd0)) begin
                errors++;
                $display("FAIL npot_flags step%0d: at_max=%b at_min=%b for out=%0d", i, max_n, min_n, exp_o[i]);
            end
        end
        load = 1'b1; load_val = 8'd15;
        tick();
        checks++;
        if (out_n !== 4'd9 || wrap_n !== 1'b0) begin
            errors++;
            $display("FAIL npot_clamp15: out=%0d wrap=%b, required 9 0", out_n, wrap_n);
        end
        load_val = 8'd3;
        tick();
        load_val = 8'd10;
        tick();
        checks++;
        if (out_n !== 4'd9) begin
            errors++;
            $display("FAIL npot_clamp10: out=%0d, required 9", out_n);
        end
        load = 1'b0; up_down = 1'b1;
        tick();
        checks++;
        if (out_n !== 4'd0 || wrap_n !== 1'b1) begin
            errors++;
            $display("FAIL npot_up_wrap: out=%0d wrap=%b, required 0 1", out_n, wrap_n);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_o [4];
        exp_o = '{8'd254, 8'd255, 8'd255, 8'd255};
        load = 1'b1; load_val = 8'd253; en = 1'b1; up_down = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_s !== exp_o[i] || wrap_s !== 1'b0) begin
                errors++;
                $display("FAIL sat_up step%0d: out=%0d wrap=%b, required %0d 0", i, out_s, wrap_s, exp_o[i]);
            end
        end
        checks++;
        if (max_s !== 1'b1 || min_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_flags_max: at_max=%b at_min=%b, required 1 0", max_s, min_s);
        end
        load = 1'b1; load_val = 8'd0;
        tick();
        load = 1'b0; up_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_s !== 8'd0 || wrap_s !== 1'b0) begin
                errors++;
                $display("FAIL sat_down step%0d: out=%0d wrap=%b, required 0 0", i, out_s, wrap_s);
            end
        end
    endtask

    task automatic test_priority_dir();
        logic [7:0] exp_o [5];
        logic       dir   [5];
        logic       ena   [5];
        exp_o = '{8'd101, 8'd100, 8'd101, 8'd101, 8'd101};
        dir   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ena   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        load = 1'b1; load_val = 8'd100; en = 1'b1; up_down = 1'b0;
        tick();
        checks++;
        if (out_w !== 8'd100) begin
            errors++;
            $display("FAIL prio_load: out=%0d, required 100", out_w);
        end
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up_down = dir[i]; en = ena[i];
            tick();
            checks++;
            if (out_w !== exp_o[i] || wrap_w !== 1'b0) begin
                errors++;
                $display("FAIL dir_step%0d: out=%0d wrap=%b, required %0d 0", i, out_w, wrap_w, exp_o[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 8'd36; en = 1'b1; up_down = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (out_w !== 8'd37) begin
            errors++;
            $display("FAIL areset_pre: out=%0d, required 37", out_w);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (out_w !== 8'd3 || wrap_w !== 1'b0 || out_n !== 4'd2) begin
            errors++;
            $display("FAIL areset_immediate: out=%0d wrap=%b out4=%0d, required 3 0 2", out_w, wrap_w, out_n);
        end
        tick();
        checks++;
        if (out_w !== 8'd3) begin
            errors++;
            $display("FAIL areset_held: out=%0d, required 3", out_w);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_w !== 8'd4) begin
            errors++;
            $display("FAIL areset_resume1: out=%0d, required 4", out_w);
        end
        tick();
        checks++;
        if (out_w !== 8'd5) begin
            errors++;
            $display("FAIL areset_resume2: out=%0d, required 5", out_w);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down_npot();
        test_saturate();
        test_priority_dir();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
